// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams PCs into a synchronous I-cache, pairs returned words with their PCs, and
// hands them to decode over valid/ready with a one-entry skid. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_misalign,
  output logic [31:0] misalign_pc
);

  typedef enum logic [1:0] {STREAM, HELD, TRAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_req, resp_pc, hold_inst, hold_pc;
  logic        resp_valid;
  logic [31:0] redir_tgt;
  logic        redir_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic [31:0] trap_pc;

  assign redir_tgt      = redirect_pc;
  assign redir_misalign = |redirect_pc[1:0];
  assign fetch_misalign = (state == TRAP);
  assign misalign_pc    = (state == TRAP) ? trap_pc : 32'h0;

  always_ff @(posedge clk) begin
    if (rst)
      trap_pc <= 32'h0;
    else if (redirect && redir_misalign)
      trap_pc <= redirect_pc;
  end
`else
  logic unused_redir_lsb;

  // Low target bits are dropped: the target is always forced word-aligned.
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_tgt        = {redirect_pc[31:2], 2'b00};
  assign redir_misalign   = 1'b0;
  assign fetch_misalign   = 1'b0;
  assign misalign_pc      = 32'h0;
`endif

  // While HELD the cache keeps re-reading resp_pc so the second word survives the stall.
  assign icache_addr = (state == HELD) ? resp_pc[31:2] : pc_req[31:2];

  always_comb begin
    state_nxt  = state;
    inst_valid = 1'b0;
    inst       = 32'h0;
    inst_pc    = 32'h0;
    case (state)
      STREAM: begin
        inst_valid = resp_valid & ~redirect;
        if (inst_valid) begin
          inst    = icache_data;
          inst_pc = resp_pc;
        end
        if (inst_valid && !inst_ready)
          state_nxt = HELD;
      end
      HELD: begin
        inst_valid = ~redirect;
        if (inst_valid) begin
          inst    = hold_inst;
          inst_pc = hold_pc;
        end
        if (inst_ready)
          state_nxt = STREAM;
      end
      TRAP: ;
      default: state_nxt = STREAM;
    endcase
    if (redirect)
      state_nxt = redir_misalign ? TRAP : STREAM;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= STREAM;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_req     <= RESET_PC;
      resp_pc    <= 32'h0;
      resp_valid <= 1'b0;
      hold_inst  <= 32'h0;
      hold_pc    <= 32'h0;
    end else if (redirect) begin
      // A misaligned target parks in TRAP without moving the fetch pointer.
      if (!redir_misalign)
        pc_req <= redir_tgt;
      resp_valid <= 1'b0;
    end else if (state == STREAM) begin
      resp_pc    <= pc_req;
      resp_valid <= 1'b1;
      pc_req     <= pc_req + 32'd4;
      if (inst_valid && !inst_ready) begin
        hold_inst <= icache_data;
        hold_pc   <= resp_pc;
      end
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side initiator for the synchronous instruction cache (word address in, registered 32-bit word out one clock later). Streams sequential PCs into the cache, pairs each returned word with its PC, and presents the pair on a valid/ready interface to decode. Handles decode back-pressure with a one-word hold register and control-flow redirects, with no lost or duplicated words. Throughput is one word per cycle.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- icache_addr  out  30  word address [31:2] to the cache
- icache_data  in  32  cache output; holds the word for the address sampled at the previous edge
- redirect  in  1  one-cycle request to change PC; has priority over everything except rst
- redirect_pc  in  32  redirect target
- inst_ready  in  1  decode accepts the current word
- inst_valid  out  1  inst/inst_pc are valid
- inst  out  32  instruction word
- inst_pc  out  32  byte PC of inst
- fetch_misalign  out  1  misaligned-target trap flag (tied 0 when the feature is off)
- misalign_pc  out  32  offending target (tied 0 when the feature is off)

## Operation
- Registers:
  - pc_req: next PC to issue.
  - resp_pc / resp_valid: PC whose word is in icache_data.
  - hold_inst / hold_pc: skid entry.
  - state ∈ {STREAM, HELD, TRAP}.
- icache_addr = (state==HELD) ? resp_pc[31:2] : pc_req[31:2].
- STREAM:
  - inst_valid = resp_valid & !redirect; inst = icache_data; inst_pc = resp_pc.
  - At the edge: resp_pc <= pc_req; resp_valid <= 1; pc_req <= pc_req+4.
  - If inst_valid & !inst_ready at that edge: also hold_inst <= icache_data; hold_pc <= resp_pc; state <= HELD.
- HELD:
  - inst_valid = !redirect; inst = hold_inst; inst_pc = hold_pc.
  - The cache re-reads resp_pc each cycle, so the second word remains available.
  - On inst_ready: state <= STREAM; pc_req and resp_pc unchanged. The next cycle presents word[resp_pc] from the cache.
- Redirect, sampled at the edge:
  - pc_req <= redirect_pc; resp_valid <= 0; state <= STREAM.
  - Any held or in-flight word is discarded.
  - The word presented during the redirect cycle is masked (inst_valid=0) and never transferred.
- inst and inst_pc read 0 whenever inst_valid=0.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
- Transfer occurs when inst_valid & inst_ready. Each PC is transferred exactly once, in order.

## Timing
- Reset: rst sampled high at edge E gives pc_req=RESET_PC, resp_valid=0, state=STREAM.
  - Outputs after E: inst_valid=0, inst=0, inst_pc=0, fetch_misalign=0, misalign_pc=0, icache_addr=RESET_PC[31:2].
- First valid word: in the second cycle after the last rst-high edge.
- Redirect in cycle n: cycle n+1 has inst_valid=0; cycle n+2 presents word[target].
- Stall entry and exit cost zero bubbles. Release in HELD at cycle m gives hold word in m, next word in m+1, then +4 each cycle.
- rst mid-operation (any state, including HELD/TRAP): all state is cleared at that edge; restarts at RESET_PC.
- redirect and inst_ready in the same HELD cycle: redirect wins; the hold word is not transferred.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]≠0 enters TRAP at the edge.
  - In TRAP: fetch_misalign=1, misalign_pc=redirect_pc, inst_valid=0, no fetch advance.
  - An aligned redirect leaves TRAP (normal redirect timing) and clears the flag. rst also leaves TRAP.
- Undefined:
  - TRAP does not exist; redirect_pc[1:0] is ignored (treated as 0).
  - fetch_misalign and misalign_pc are tied 0.

## Test plan
- Reset with RESET_PC=0, ready=1, cache loaded with CSR test words → inst_valid rises the second cycle after reset; pairs (0x0,0x00000193), (0x4,0x00f00093), (0x8,0x00009073) on consecutive cycles.
- Ready low for 3 cycles while pc 0x8 is presented → inst/inst_pc hold 0x8/0x00009073. After release: 0x8, 0xC (0x00003173), 0x10 (0x06111063) on consecutive cycles; no gap, no duplicate.
- Redirect to 0x6C in cycle n → cycle n+1 invalid; cycle n+2 presents pc 0x6C, inst 0xffdff06f; cycle n+3 presents pc 0x70, inst 0x0000006f.
- Redirect to 0x28 while HELD at 0x14 → held word never transferred; pc 0x28 (0x00100093) presented two cycles later.
- rst pulsed during HELD → inst_valid=0 next cycle; stream restarts at RESET_PC. With RESET_PC=0xFFFF_FFFC, the PC after 0xFFFF_FFFC is 0x0.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → fetch_misalign=1 and misalign_pc=0x102 next cycle, inst_valid stays 0; redirect to 0x100 → flag clears, pc 0x100 presented two cycles later.
